// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: owns the A/B term registers and their adder, and streams
// the first n_terms terms over a valid/ready handshake before pulsing done.
module fib_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_term,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum;
    logic             lastIdx;
    logic             newTermEmitted;

    // The freshly computed B is term idx+2; it only counts toward overflow
    // if this run will actually emit it.
    assign sum            = {1'b0, a_q} + {1'b0, b_q};
    assign lastIdx        = (idx_q == (n_q - CNT_W'(1)));
    assign newTermEmitted = (({1'b0, idx_q} + (CNT_W+1)'(2)) < {1'b0, n_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        n_d       = n_q;
        ovf_d     = ovf_q;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (n_terms != '0) begin
                        n_d     = n_terms;
                        a_d     = '0;
                        b_d     = WIDTH'(1);
                        idx_d   = '0;
                        state_d = EMIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // Abort wins over a same-cycle handshake; that term is dropped.
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (lastIdx) begin
                        state_d = DONE;
                    end else begin
                        a_d   = b_q;
                        b_d   = sum[WIDTH-1:0];
                        idx_d = idx_q + CNT_W'(1);
                        if (sum[WIDTH] && newTermEmitted) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_term = a_q;
    assign out_idx  = idx_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: a reference Fibonacci model fills a
// scoreboard at each start, and accepted terms are popped and compared.
module tb_fib_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] term;
        logic [CNT_W-1:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] n_terms;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_term;
    logic [CNT_W-1:0] out_idx;
    logic             busy;
    logic             done;
    logic             overflow;

    int   total = 0;
    int   bad   = 0;
    exp_t sbQ[$];
    int   ovfThreshold;

    fib_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_terms   (n_terms),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_term  (out_term),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge and loads the scoreboard with the true
    // sequence; ovfThreshold is the handshake count after which the
    // first emitted term whose true value exceeds 2^WIDTH-1 has been computed.
    task automatic applyStimulus(input int n);
        int a;
        int b;
        int t;
        sbQ.delete();
        ovfThreshold = -1;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            sbQ.push_back('{term: WIDTH'(a % (1 << WIDTH)), idx: CNT_W'(i)});
            if (a > (1 << WIDTH) - 1 && ovfThreshold < 0) ovfThreshold = i - 1;
            t = a + b;
            a = b;
            b = t;
        end
        start   = 1'b1;
        n_terms = CNT_W'(n);
        tick();
        start   = 1'b0;
    endtask

    task automatic runTerms(input int n, input logic [31:0] pat, input int patLen,
                            input int abortIdx, input int budget,
                            output int cycles, output int hs);
        bit               held;
        bit               finished;
        logic [WIDTH-1:0] heldTerm;
        logic [CNT_W-1:0] heldIdx;
        exp_t             e;
        held     = 1'b0;
        finished = 1'b0;
        hs       = 0;
        cycles   = -1;
        heldTerm = '0;
        heldIdx  = '0;
        applyStimulus(n);
        for (int k = 0; k < budget && !finished; k++) begin
            out_ready = pat[k % patLen];
            checkOutput("overflow", overflow, (ovfThreshold >= 0 && hs >= ovfThreshold));
            if (done) begin
                checkOutput("validInDone", out_valid, 0);
                checkOutput("busyInDone", busy, 1);
                finished = 1'b1;
                cycles   = k;
            end else begin
                checkOutput("validOrDone", out_valid, 1);
                checkOutput("busyInEmit", busy, 1);
                if (held) begin
                    checkOutput("holdTerm", out_term, heldTerm);
                    checkOutput("holdIdx", out_idx, heldIdx);
                end
                if (abortIdx >= 0 && int'(out_idx) == abortIdx) begin
                    abort    = 1'b1;
                    finished = 1'b1;
                    cycles   = k;
                end else if (out_ready) begin
                    checkOutput("sbNotEmpty", sbQ.size() > 0, 1);
                    if (sbQ.size() > 0) begin
                        e = sbQ.pop_front();
                        checkOutput("term", out_term, e.term);
                        checkOutput("idx", out_idx, e.idx);
                    end
                    hs++;
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    heldTerm = out_term;
                    heldIdx  = out_idx;
                end
            end
            tick();
        end
        checkOutput("runFinished", finished, 1);
        abort     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int   cycles;
        int   hs;
        bit   stop;
        exp_t e;

        reset     = 1'b1;
        start     = 1'b0;
        n_terms   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rstValid", out_valid, 0);
        checkOutput("rstTerm", out_term, 0);
        checkOutput("rstIdx", out_idx, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstOvf", overflow, 0);
        reset = 1'b0;
        tick();

        $display("[TB] run n=8, ready always high");
        runTerms(8, 32'h1, 1, -1, 40, cycles, hs);
        checkOutput("n8Cycles", cycles, 8);
        checkOutput("n8Handshakes", hs, 8);
        checkOutput("n8Leftover", sbQ.size(), 0);
        checkOutput("n8DoneOnce", done, 0);
        checkOutput("n8Idle", busy, 0);
        checkOutput("n8Ovf", overflow, 0);

        $display("[TB] run n=10, overflow expected");
        runTerms(10, 32'h1, 1, -1, 40, cycles, hs);
        checkOutput("n10Cycles", cycles, 10);
        checkOutput("n10Handshakes", hs, 10);
        checkOutput("n10OvfSticky", overflow, 1);

        $display("[TB] run n=0");
        applyStimulus(0);
        checkOutput("n0Valid", out_valid, 0);
        checkOutput("n0Done", done, 1);
        checkOutput("n0Busy", busy, 1);
        checkOutput("n0OvfCleared", overflow, 0);
        tick();
        checkOutput("n0DoneOnce", done, 0);
        checkOutput("n0Idle", busy, 0);

        $display("[TB] run n=4, ready toggling");
        runTerms(4, 32'b1101001, 7, -1, 40, cycles, hs);
        checkOutput("n4Cycles", cycles, 7);
        checkOutput("n4Handshakes", hs, 4);
        checkOutput("n4Leftover", sbQ.size(), 0);

        $display("[TB] run n=12 with abort at idx 5");
        runTerms(12, 32'h1, 1, 5, 40, cycles, hs);
        checkOutput("abortCycles", cycles, 5);
        checkOutput("abortHandshakes", hs, 5);
        checkOutput("abortLeftover", sbQ.size(), 7);
        checkOutput("abortValid", out_valid, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortBusy", busy, 0);
        tick();
        checkOutput("abortNoDoneLater", done, 0);
        runTerms(3, 32'h1, 1, -1, 20, cycles, hs);
        checkOutput("n3Cycles", cycles, 3);
        checkOutput("n3Handshakes", hs, 3);

        $display("[TB] reset mid-run with stray start pulses");
        applyStimulus(8);
        out_ready = 1'b1;
        stop      = 1'b0;
        for (int k = 0; k < 20 && !stop; k++) begin
            start   = (k == 1);
            n_terms = (k == 1) ? CNT_W'(2) : CNT_W'(8);
            checkOutput("rrValid", out_valid, 1);
            if (out_idx == CNT_W'(3)) begin
                stop = 1'b1;
            end else if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("rrTerm", out_term, e.term);
                checkOutput("rrIdx", out_idx, e.idx);
                tick();
            end
        end
        checkOutput("rrReachedIdx3", stop, 1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        checkOutput("rrValid0", out_valid, 0);
        checkOutput("rrTerm0", out_term, 0);
        checkOutput("rrIdx0", out_idx, 0);
        checkOutput("rrBusy0", busy, 0);
        checkOutput("rrDone0", done, 0);
        checkOutput("rrOvf0", overflow, 0);
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        tick();
        checkOutput("rrStillIdleValid", out_valid, 0);
        checkOutput("rrStillIdleBusy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
